// File: rtl/order_tx.sv
// ---------------------------------------------------------------------------
// order_tx
//   Turns single-cycle trading decisions into 5-byte order frames on a
//   valid/ready byte stream. Qualifying decisions are queued in a small FIFO
//   and sent in arrival order. Each frame is:
//     0xA5 header, side (0x01 buy / 0x02 sell), price, sequence number,
//     XOR checksum of the four preceding bytes.
//
// Parameters
//   data_width : width of price and of each frame byte (only 8 is supported)
//   fifo_depth : order queue entries, power of 2 in the range 2..16
//
// Ports
//   clk         : single clock, everything on the rising edge
//   rst         : asynchronous active-high reset
//   data_valid  : decision strobe, one cycle per decision
//   buy_signal  : buy decision, qualified by data_valid
//   sell_signal : sell decision, qualified by data_valid
//   price       : price sample paired with the decision
//   tx_data     : current frame byte
//   tx_valid    : tx_data is valid
//   tx_ready    : downstream takes the byte when tx_valid && tx_ready
//   tx_last     : high with the final (checksum) byte
//   overflow    : one-cycle pulse when an order was dropped on a full queue
//   fifo_count  : number of queued orders, 0..fifo_depth
// ---------------------------------------------------------------------------
module order_tx #(
  parameter int data_width = 8,
  parameter int fifo_depth = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          data_valid,
  input  logic                          buy_signal,
  input  logic                          sell_signal,
  input  logic [data_width-1:0]         price,
  output logic [data_width-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic                          tx_last,
  output logic                          overflow,
  output logic [$clog2(fifo_depth):0]   fifo_count
);

  localparam int addr_width  = $clog2(fifo_depth);
  localparam int count_width = addr_width + 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] HDR   = 3'd1;
  localparam logic [2:0] SIDE  = 3'd2;
  localparam logic [2:0] PRICE = 3'd3;
  localparam logic [2:0] SEQ   = 3'd4;
  localparam logic [2:0] CSUM  = 3'd5;

  localparam logic [data_width-1:0] HDR_BYTE  = data_width'('hA5);
  localparam logic [data_width-1:0] BUY_BYTE  = data_width'('h01);
  localparam logic [data_width-1:0] SELL_BYTE = data_width'('h02);

  logic [2:0]             state;
  logic                   push_req;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;
  logic [addr_width-1:0]  rd_ptr;
  logic [addr_width-1:0]  wr_ptr;
  logic [count_width-1:0] count;

  // The side is kept as a single bit (1 = sell) and expanded to a byte on the way out.
  logic                   side_mem  [fifo_depth];
  logic [data_width-1:0]  price_mem [fifo_depth];

  logic                   frame_sell;
  logic [data_width-1:0]  frame_price;
  logic [data_width-1:0]  seq;
  logic [data_width-1:0]  side_byte;
  logic [data_width-1:0]  csum_byte;

  // A decision only counts when exactly one of buy/sell is set. A pop frees
  // a slot in the same cycle, so a full queue can still take an order if the
  // FSM is popping the head at that moment.
  assign push_req = data_valid && (buy_signal != sell_signal);
  assign full     = (count == count_width'(fifo_depth));
  assign empty    = (count == '0);
  assign pop      = (state == IDLE) && !empty;
  assign push     = push_req && (!full || pop);

  // Queue storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (push) begin
      side_mem[wr_ptr]  <= sell_signal;
      price_mem[wr_ptr] <= price;
    end
  end

  // Pointers and occupancy. Depth is a power of two so the pointers wrap by
  // natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + addr_width'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + addr_width'(1);
      end
      count <= count + count_width'(push) - count_width'(pop);
    end
  end

  // Dropped orders are reported one cycle after the rejected decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else begin
      overflow <= push_req && full && !pop;
    end
  end

  // Frame sequencer. IDLE pops the head into the frame registers; every
  // other state holds its byte until the downstream accepts it. Passing
  // through IDLE after the checksum guarantees a gap cycle between frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      seq         <= '0;
      frame_sell  <= 1'b0;
      frame_price <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            frame_sell  <= side_mem[rd_ptr];
            frame_price <= price_mem[rd_ptr];
            state       <= HDR;
          end
        end
        HDR: begin
          if (tx_ready) begin
            state <= SIDE;
          end
        end
        SIDE: begin
          if (tx_ready) begin
            state <= PRICE;
          end
        end
        PRICE: begin
          if (tx_ready) begin
            state <= SEQ;
          end
        end
        SEQ: begin
          if (tx_ready) begin
            state <= CSUM;
          end
        end
        CSUM: begin
          if (tx_ready) begin
            state <= IDLE;
            seq   <= seq + data_width'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output bytes come straight from the state and the frame registers, which
  // are frozen while a byte is stalled, so tx_data/tx_last cannot change
  // until the byte is accepted. Reset forces IDLE and therefore zeros.
  assign side_byte = frame_sell ? SELL_BYTE : BUY_BYTE;
  assign csum_byte = HDR_BYTE ^ side_byte ^ frame_price ^ seq;

  always_comb begin
    tx_data = '0;
    case (state)
      HDR:     tx_data = HDR_BYTE;
      SIDE:    tx_data = side_byte;
      PRICE:   tx_data = frame_price;
      SEQ:     tx_data = seq;
      CSUM:    tx_data = csum_byte;
      default: tx_data = '0;
    endcase
  end

  assign tx_valid   = (state != IDLE);
  assign tx_last    = (state == CSUM);
  assign fifo_count = count;

endmodule
